// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator for the head of the fetch stage.
// It holds the current PC and picks the next one from four sources, in this
// priority order: trap, branch, return, then sequential.
// A branch or return target that is not instruction-aligned parks the
// generator in FAULT. Only a trap leaves FAULT.
// Optional feature: define CBL_RAS_EN to add a circular return-address stack.
// The stack predicts return targets.
module pc_gen #(
  parameter int                    PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                    INSTR_BYTES  = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_stall,
  input  logic                i_fetch_ready,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_trap,
  input  logic [PC_WIDTH-1:0] i_trap_vector,
  input  logic                i_call,
  input  logic [PC_WIDTH-1:0] i_link_addr,
  input  logic                i_ret,
  input  logic [PC_WIDTH-1:0] i_ret_target,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] o_pc_next,
  output logic                o_fetch_valid,
  output logic                o_misaligned,
  output logic                o_ras_empty
);

  // Low-bit mask of an instruction address. It is zero for INSTR_BYTES=1,
  // which disables the alignment check entirely.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(INSTR_BYTES);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, mis_q;
  logic                push, pop;
  logic                ras_hit;
  logic [PC_WIDTH-1:0] ras_top;
  logic [PC_WIDTH-1:0] ret_tgt;

  function automatic logic is_misaligned(input logic [PC_WIDTH-1:0] a);
    return |(a & ALIGN_MASK);
  endfunction

  assign ret_tgt = ras_hit ? ras_top : i_ret_target;

  // Next-PC selection and state transition.
  // Redirects take effect regardless of stall and ready.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        push = i_call & ~i_trap;
        if (i_trap) begin
          pc_d = i_trap_vector & ~ALIGN_MASK;
        end else if (i_branch_taken) begin
          pc_d = i_branch_target;
          if (is_misaligned(i_branch_target)) state_d = S_FAULT;
        end else if (i_ret) begin
          pc_d = ret_tgt;
          if (is_misaligned(ret_tgt)) state_d = S_FAULT;
          else                        pop     = ras_hit;
        end else if (i_stall || !i_fetch_ready) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + PC_INC;
        end
      end
      S_FAULT: begin
        if (i_trap) begin
          pc_d    = i_trap_vector & ~ALIGN_MASK;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State, PC and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == S_RUN);
      mis_q   <= (state_d == S_FAULT);
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_next     = pc_d;
  assign o_fetch_valid = valid_q;
  assign o_misaligned  = mis_q;

`ifdef CBL_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

  // sp_q is the next write slot. The top of stack is at sp_q-1.
  // cnt_q saturates at RAS_DEPTH, so a push on a full stack overwrites the oldest entry.
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    sp_q, sp_d, wr_idx;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                wr_en;

  assign ras_hit     = (cnt_q != '0);
  assign ras_top     = ras_mem[sp_q - PTR_W'(1)];
  assign o_ras_empty = (cnt_q == '0);

  // Stack pointer update. A pop and a push in the same cycle replace the
  // top entry in place.
  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr_idx = sp_q;
    wr_en  = 1'b0;
    if (pop && push) begin
      wr_idx = sp_q - PTR_W'(1);
      wr_en  = 1'b1;
    end else if (pop) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end else if (push) begin
      wr_en = 1'b1;
      sp_d  = sp_q + PTR_W'(1);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + (PTR_W+1)'(1);
    end
  end

  // Stack pointers clear on reset. A trap leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage. Unused entries are never read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= i_link_addr;
  end
`else
  logic unused_ras;

  assign ras_hit     = 1'b0;
  assign ras_top     = '0;
  assign o_ras_empty = 1'b1;
  assign unused_ras  = ^{i_call, i_link_addr, push, pop};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: RESET_VECTOR=0x100, INSTR_BYTES=4.
// It builds with or without CBL_RAS_EN.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall, i_fetch_ready, i_branch_taken, i_trap, i_call, i_ret;
  logic [31:0] i_branch_target, i_trap_vector, i_link_addr, i_ret_target;
  logic [31:0] o_pc, o_pc_next;
  logic        o_fetch_valid, o_misaligned, o_ras_empty;

  int nchk = 0;
  int nerr = 0;

  pc_gen #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(32'h0000_0100),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (i_stall),
    .i_fetch_ready  (i_fetch_ready),
    .i_branch_taken (i_branch_taken),
    .i_branch_target(i_branch_target),
    .i_trap         (i_trap),
    .i_trap_vector  (i_trap_vector),
    .i_call         (i_call),
    .i_link_addr    (i_link_addr),
    .i_ret          (i_ret),
    .i_ret_target   (i_ret_target),
    .o_pc           (o_pc),
    .o_pc_next      (o_pc_next),
    .o_fetch_valid  (o_fetch_valid),
    .o_misaligned   (o_misaligned),
    .o_ras_empty    (o_ras_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, ready, br;
    logic [31:0] brt;
    logic        trap;
    logic [31:0] tv;
    logic        ret;
    logic [31:0] rett;
    logic        call;
    logic [31:0] link;
    logic [31:0] e_next, e_pc;
    logic        e_valid, e_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic stall, ready, br, input logic [31:0] brt,
                              input logic trap, input logic [31:0] tv,
                              input logic ret, input logic [31:0] rett,
                              input logic [31:0] e_next, e_pc,
                              input logic e_valid, e_mis);
    vec_t v;
    v.stall = stall; v.ready = ready; v.br = br; v.brt = brt;
    v.trap = trap; v.tv = tv; v.ret = ret; v.rett = rett;
    v.call = 1'b0; v.link = '0;
    v.e_next = e_next; v.e_pc = e_pc; v.e_valid = e_valid; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_stall = v.stall; i_fetch_ready = v.ready;
    i_branch_taken = v.br; i_branch_target = v.brt;
    i_trap = v.trap; i_trap_vector = v.tv;
    i_ret = v.ret; i_ret_target = v.rett;
    i_call = v.call; i_link_addr = v.link;
  endtask

  // Drive after a falling edge, check the combinational next PC, then check
  // the registered state after the rising edge.
  task automatic run_vec(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({name, "_next"}, o_pc_next, v.e_next);
    @(posedge clk);
    #1;
    chk({name, "_pc"}, o_pc, v.e_pc);
    chk({name, "_valid"}, 32'(o_fetch_valid), 32'(v.e_valid));
    chk({name, "_mis"}, 32'(o_misaligned), 32'(v.e_mis));
  endtask

  vec_t        v;
  logic [31:0] ret_exp [5];
  logic        ras_on;

  initial begin
`ifdef CBL_RAS_EN
    ras_on = 1'b1;
    ret_exp = '{32'h50, 32'h40, 32'h30, 32'h20, 32'hF00};
`else
    ras_on = 1'b0;
    ret_exp = '{32'hF00, 32'hF00, 32'hF00, 32'hF00, 32'hF00};
`endif
    //            stall rdy br brt           trap tv          ret rett        next          pc            vld mis
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,   32'h104,      32'h104,      1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,   32'h104,      32'h104,      1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,   32'h104,      32'h104,      1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h200,      0, 32'h0,    0, 32'h0,   32'h200,      32'h200,      1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,   32'h200,      32'h200,      1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,   32'h204,      32'h204,      1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h300,      1, 32'h8003, 1, 32'h500, 32'h8000,     32'h8000,     1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,    1, 32'h500, 32'h500,      32'h500,      1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h202,      0, 32'h0,    0, 32'h0,   32'h202,      32'h202,      0, 1));
    tbl.push_back(mk(0, 1, 1, 32'h300,      0, 32'h0,    0, 32'h0,   32'h202,      32'h202,      0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,    1, 32'h600, 32'h202,      32'h202,      0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h40,   0, 32'h0,   32'h40,       32'h40,       1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,    1, 32'h46,  32'h46,       32'h46,       0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h7F,   0, 32'h0,   32'h7C,       32'h7C,       1, 0));
    tbl.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,    0, 32'h0,   32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,   32'h0,        32'h0,        1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,   32'h4,        32'h4,        1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h100,  0, 32'h0,   32'h100,      32'h100,      1, 0));

    // Asynchronous reset before any clock edge.
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", o_pc, 32'h100);
    chk("rst_valid", 32'(o_fetch_valid), 32'h0);
    chk("rst_mis", 32'(o_misaligned), 32'h0);
    chk("rst_ras_empty", 32'(o_ras_empty), 32'h1);
    repeat (2) @(posedge clk);

    // Release reset. There is one BOOT cycle with valid low; the trap driven
    // during BOOT must be ignored.
    @(negedge clk);
    rst = 1'b0;
    i_trap = 1'b1; i_trap_vector = 32'h900;
    #1;
    chk("boot_pc", o_pc, 32'h100);
    chk("boot_next", o_pc_next, 32'h100);
    chk("boot_valid", 32'(o_fetch_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("run0_pc", o_pc, 32'h100);
    chk("run0_valid", 32'(o_fetch_valid), 32'h1);

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("v%0d", i), tbl[i]);

    // Push five return addresses, then pop five returns.
    for (int i = 0; i < 5; i++) begin
      v = mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h104 + 32'(4*i), 32'h104 + 32'(4*i), 1, 0);
      v.call = 1'b1;
      v.link = 32'h10 * 32'(i + 1);
      run_vec($sformatf("push%0d", i), v);
      chk($sformatf("push%0d_empty", i), 32'(o_ras_empty), 32'(!ras_on));
    end
    for (int i = 0; i < 5; i++) begin
      v = mk(0, 1, 0, 0, 0, 0, 1, 32'hF00, ret_exp[i], ret_exp[i], 1, 0);
      run_vec($sformatf("pop%0d", i), v);
    end
    chk("pop_all_empty", 32'(o_ras_empty), 32'h1);

    // A return and a call in the same cycle replace the top entry.
    v = mk(0, 1, 0, 0, 0, 0, 0, 0, 32'hF04, 32'hF04, 1, 0);
    v.call = 1'b1; v.link = 32'h10;
    run_vec("rc_push", v);
    v = mk(0, 1, 0, 0, 0, 0, 1, 32'hF00, ras_on ? 32'h10 : 32'hF00, ras_on ? 32'h10 : 32'hF00, 1, 0);
    v.call = 1'b1; v.link = 32'h20;
    run_vec("rc_both", v);
    chk("rc_both_empty", 32'(o_ras_empty), 32'(!ras_on));
    v = mk(0, 1, 0, 0, 0, 0, 1, 32'hF00, ras_on ? 32'h20 : 32'hF00, ras_on ? 32'h20 : 32'hF00, 1, 0);
    run_vec("rc_pop", v);
    chk("rc_pop_empty", 32'(o_ras_empty), 32'h1);

    // Enter FAULT while pushing, then assert reset mid-cycle.
    v = mk(0, 1, 1, 32'h6, 0, 0, 0, 0, 32'h6, 32'h6, 0, 1);
    v.call = 1'b1; v.link = 32'h99;
    run_vec("pre_rst", v);
    @(negedge clk);
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", o_pc, 32'h100);
    chk("arst_valid", 32'(o_fetch_valid), 32'h0);
    chk("arst_mis", 32'(o_misaligned), 32'h0);
    chk("arst_ras_empty", 32'(o_ras_empty), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reboot_pc", o_pc, 32'h100);
    chk("reboot_valid", 32'(o_fetch_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator replacing the single-register program counter at the head of the fetch stage. Holds the current PC and chooses the next PC from trap, branch, return and sequential sources. Handshakes with instruction memory, traps misaligned control-flow targets in a fault state, and optionally predicts returns with a small return-address stack. Drives the instruction-memory address and feeds the current PC to decode for link/branch arithmetic.

## Interface
- PC_WIDTH, 32, width of all address ports and the PC register
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- INSTR_BYTES, 4, sequential increment; power of two ≥ 1; alignment = log2(INSTR_BYTES) low bits
- RAS_DEPTH, 4, return-address-stack entries (power of two ≥ 2; used only with CBL_RAS_EN)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_stall  in  1  hold PC (downstream stall)
- i_fetch_ready  in  1  instruction memory accepts the address this cycle
- i_branch_taken  in  1  redirect to i_branch_target
- i_branch_target  in  PC_WIDTH  branch/jump target
- i_trap  in  1  redirect to i_trap_vector
- i_trap_vector  in  PC_WIDTH  trap handler address; low alignment bits forced to 0 internally
- i_call  in  1  push i_link_addr onto the RAS
- i_link_addr  in  PC_WIDTH  return address to push
- i_ret  in  1  return redirect
- i_ret_target  in  PC_WIDTH  architectural return target
- o_pc  out  PC_WIDTH  current PC (registered)
- o_pc_next  out  PC_WIDTH  value o_pc takes at next edge (combinational)
- o_fetch_valid  out  1  o_pc is a valid fetch request
- o_misaligned  out  1  in FAULT state
- o_ras_empty  out  1  RAS has no entries (constant 1 without CBL_RAS_EN)

## Operation
- States: BOOT, RUN, FAULT. Reset → BOOT, o_pc=RESET_VECTOR, o_fetch_valid=0, o_misaligned=0, RAS empty.
- BOOT: one cycle, o_fetch_valid=0, all inputs ignored; → RUN.
- RUN: o_fetch_valid=1. Next-PC priority: i_trap > i_branch_taken > i_ret > hold > sequential.
  - trap: o_pc ← i_trap_vector with low bits cleared; stays RUN.
  - branch: o_pc ← i_branch_target.
  - ret: o_pc ← RAS top if CBL_RAS_EN and RAS non-empty (pop), else i_ret_target.
  - hold when i_stall=1 or i_fetch_ready=0; redirects ignore stall/ready.
  - sequential: o_pc ← o_pc + INSTR_BYTES, modulo 2^PC_WIDTH (wraps to 0).
- Misalignment: a selected branch or ret target with any nonzero low alignment bit → FAULT, o_pc ← that target (handler inspects it), no pop.
- FAULT: o_fetch_valid=0, o_misaligned=1, PC held; only i_trap exits (→ RUN, o_pc ← aligned vector). Other inputs ignored, no RAS activity.
- i_call honoured in RUN when i_trap=0, independent of branch/stall.

## Timing
- Redirects and increments take effect at the next rising edge; o_pc_next reflects the selection combinationally in the same cycle.
- Zero-bubble redirect: new PC is valid the cycle after the redirect input.
- Reset asserted mid-operation: o_pc, state and RAS pointers clear immediately (asynchronous), no clock needed.
- INSTR_BYTES=1: alignment check disabled, FAULT unreachable.

## Configuration
- CBL_RAS_EN defined: RAS of RAS_DEPTH entries, circular. Push on full overwrites oldest; pop on empty falls back to i_ret_target. Same-cycle ret+call: pop then push (top replaced by i_link_addr). Trap does not clear the RAS.
- Undefined: no storage; i_call and i_link_addr ignored; ret always uses i_ret_target; o_ras_empty=1.

## Test plan
- Reset release, RESET_VECTOR=0x100, ready=1: BOOT cycle with valid=0 at 0x100, then o_pc 0x100, 0x104, 0x108 with valid=1.
- i_stall=1 two cycles at 0x104, then a branch to 0x200 while stalled: PC holds 0x104, next edge 0x200.
- Trap, branch to 0x300 and ret in one cycle, trap vector 0x8003: o_pc=0x8000.
- Branch to 0x202 (INSTR_BYTES=4): FAULT, o_pc=0x202, valid=0, misaligned=1. Branch ignored. Trap to 0x40 → RUN at 0x40.
- CBL_RAS_EN, depth 4: push 0x10,0x20,0x30,0x40,0x50, then five rets with i_ret_target=0xF00. Targets are 0x50,0x40,0x30,0x20, then 0xF00 (empty).
- PC at 0xFFFF_FFFC sequential: next o_pc=0x0000_0000.
